ps2_lane_keys: RTL and testbench

- Parametrised PS/2 keyboard front end; successor to the single-key-code receiver.
- Deserialises PS/2 frames, checks parity and stop bits, and decodes the make, break (F0) and extended (E0) sequences.
- Tracks held state for NUM_KEYS configurable lane keys and queues decoded key events in a small FIFO for the game FSM.
- Sits between the board PS/2 pins and the 4kmania judge and menu logic.

---
 rtl/ps2_kbd_pkg.sv | 24 ++
 rtl/ps2_frame_rx.sv | 159 +++++++++++++++
 rtl/ps2_lane_keys.sv | 145 ++++++++++++++
 tb/tb_ps2_lane_keys.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_kbd_pkg.sv
// Shared constants and types for the PS/2 lane-key front end.
package ps2_kbd_pkg;

    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE   = 8'hE0;

    localparam logic [7:0] CODE_A     = 8'h1C;
    localparam logic [7:0] CODE_S     = 8'h1B;
    localparam logic [7:0] CODE_K     = 8'h42;
    localparam logic [7:0] CODE_L     = 8'h4B;
    localparam logic [7:0] CODE_ENTER = 8'h5A;

    // Index 0 sits in the least significant byte.
    localparam logic [39:0] DEFAULT_KEY_CODES = {CODE_ENTER, CODE_L, CODE_K, CODE_S, CODE_A};

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_e;

    typedef struct packed {
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } key_evt_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line conditioning and 11-bit frame receiver with parity, stop-bit and timeout checks.
//   state  | meaning
//   IDLE   | waiting for a start bit (0) on a clock falling edge
//   DATA   | shifting in 8 data bits, LSB first
//   PARITY | capturing the parity bit
//   STOP   | checking the stop bit and releasing the byte
module ps2_frame_rx
    import ps2_kbd_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int PARITY_CHECK   = 1
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       key_clk,
    input  logic       key_data,
    output logic       byte_valid,
    output logic [7:0] data_byte,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] F_RELOAD = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] T_RELOAD = TW'(TIMEOUT_CYCLES - 1);

    // Bit 0 carries the clock line, bit 1 the data line.
    logic [1:0]    s1_q, s2_q, filt_q;
    logic [FW-1:0] fcnt_q [2];
    logic          clk_prev_q;

    rx_state_e     state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          armed_q, armed_d;
    logic [FW-1:0] idle_cnt_q, idle_cnt_d;

    logic fall, din, par_ok;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            s1_q       <= 2'b11;
            s2_q       <= 2'b11;
            filt_q     <= 2'b11;
            clk_prev_q <= 1'b1;
            for (int i = 0; i < 2; i++) fcnt_q[i] <= F_RELOAD;
        end else begin
            s1_q       <= {key_data, key_clk};
            s2_q       <= s1_q;
            clk_prev_q <= filt_q[0];
            for (int i = 0; i < 2; i++) begin
                if (s2_q[i] == filt_q[i]) begin
                    fcnt_q[i] <= F_RELOAD;
                end else if (fcnt_q[i] == '0) begin
                    filt_q[i] <= s2_q[i];
                    fcnt_q[i] <= F_RELOAD;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] - 1'b1;
                end
            end
        end
    end

    assign fall      = clk_prev_q & ~filt_q[0];
    assign din       = filt_q[1];
    assign par_ok    = ^{shift_q, par_q};
    assign data_byte = shift_q;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            to_cnt_q   <= T_RELOAD;
            armed_q    <= 1'b0;
            idle_cnt_q <= F_RELOAD;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            to_cnt_q   <= to_cnt_d;
            armed_q    <= armed_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        to_cnt_d   = to_cnt_q;
        armed_d    = armed_q;
        idle_cnt_d = idle_cnt_q;
        byte_valid = 1'b0;
        parity_err = 1'b0;
        frame_err  = 1'b0;

        if (fall) begin
            to_cnt_d = T_RELOAD;
        end else if (state_q != IDLE && to_cnt_q != '0) begin
            to_cnt_d = to_cnt_q - 1'b1;
        end

        // After reset, both lines must idle high before a start bit is trusted.
        if (!armed_q) begin
            if (filt_q == 2'b11) begin
                if (idle_cnt_q == '0) armed_d = 1'b1;
                else                  idle_cnt_d = idle_cnt_q - 1'b1;
            end else begin
                idle_cnt_d = F_RELOAD;
            end
        end

        case (state_q)
            IDLE: begin
                if (fall && armed_q && !din) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_d   = {din, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
            end
            PARITY: begin
                if (fall) begin
                    par_d   = din;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_d    = IDLE;
                    parity_err = (PARITY_CHECK != 0) && !par_ok;
                    frame_err  = !din;
                    byte_valid = din && (par_ok || PARITY_CHECK == 0);
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && !fall && to_cnt_q == '0) begin
            state_d    = IDLE;
            frame_err  = 1'b1;
            byte_valid = 1'b0;
        end
    end

endmodule

// File: rtl/ps2_lane_keys.sv
// PS/2 keyboard front end: make/break/extended decode, lane-key held state and a FWFT event FIFO.
module ps2_lane_keys
    import ps2_kbd_pkg::*;
#(
    parameter int                      NUM_KEYS       = 5,
    parameter logic [8*NUM_KEYS-1:0]   KEY_CODES      = DEFAULT_KEY_CODES,
    parameter int                      FILTER_LEN     = 4,
    parameter int                      TIMEOUT_CYCLES = 10000,
    parameter int                      PARITY_CHECK   = 1,
    parameter int                      FIFO_DEPTH     = 8
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic                key_clk,
    input  logic                key_data,
    output logic [NUM_KEYS-1:0] key_down,
    output logic [NUM_KEYS-1:0] key_press,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [7:0]          evt_code,
    output logic                evt_break,
    output logic                evt_ext,
    output logic                parity_err,
    output logic                frame_err,
    output logic                overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic       rx_valid, rx_perr, rx_ferr;
    logic [7:0] rx_byte;

    ps2_frame_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .PARITY_CHECK  (PARITY_CHECK)
    ) u_rx (
        .clk_in    (clk_in),
        .rst       (rst),
        .key_clk   (key_clk),
        .key_data  (key_data),
        .byte_valid(rx_valid),
        .data_byte (rx_byte),
        .parity_err(rx_perr),
        .frame_err (rx_ferr)
    );

    logic                brk_q, brk_d, ext_q, ext_d;
    logic [NUM_KEYS-1:0] key_down_q, key_down_d, key_press_q, key_press_d;
    logic                push_q, push_d;
    key_evt_t            push_evt_q, push_evt_d;
    logic                parity_err_q, frame_err_q, overflow_q;

    always_comb begin
        brk_d       = brk_q;
        ext_d       = ext_q;
        key_down_d  = key_down_q;
        key_press_d = '0;
        push_d      = 1'b0;
        push_evt_d  = push_evt_q;
        if (rx_valid) begin
            if (rx_byte == BREAK_CODE) begin
                brk_d = 1'b1;
            end else if (rx_byte == EXT_CODE) begin
                ext_d = 1'b1;
            end else begin
                push_d     = 1'b1;
                push_evt_d = '{code: rx_byte, brk: brk_q, ext: ext_q};
                brk_d      = 1'b0;
                ext_d      = 1'b0;
                for (int i = 0; i < NUM_KEYS; i++) begin
                    if (!ext_q && rx_byte == KEY_CODES[8*i +: 8]) begin
                        if (brk_q) begin
                            key_down_d[i] = 1'b0;
                        end else begin
                            key_down_d[i]  = 1'b1;
                            key_press_d[i] = ~key_down_q[i];
                        end
                    end
                end
            end
        end
    end

    key_evt_t          mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q;
    logic              pop, full, wr_en;
    key_evt_t          head;

    assign full  = (count_q == (AW+1)'(FIFO_DEPTH));
    assign pop   = evt_valid & evt_ready;
    assign wr_en = push_q & (~full | pop);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            brk_q        <= 1'b0;
            ext_q        <= 1'b0;
            key_down_q   <= '0;
            key_press_q  <= '0;
            push_q       <= 1'b0;
            push_evt_q   <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            brk_q        <= brk_d;
            ext_q        <= ext_d;
            key_down_q   <= key_down_d;
            key_press_q  <= key_press_d;
            push_q       <= push_d;
            push_evt_q   <= push_evt_d;
            parity_err_q <= rx_perr;
            frame_err_q  <= rx_ferr;
            overflow_q   <= overflow_q | (push_q & full & ~pop);
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; the head is masked while the FIFO is empty.
    always_ff @(posedge clk_in) begin
        if (wr_en) mem[wr_ptr_q] <= push_evt_q;
    end

    assign head       = mem[rd_ptr_q];
    assign evt_valid  = (count_q != '0);
    assign evt_code   = evt_valid ? head.code : 8'h00;
    assign evt_break  = evt_valid & head.brk;
    assign evt_ext    = evt_valid & head.ext;
    assign key_down   = key_down_q;
    assign key_press  = key_press_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_lane_keys.sv
// Randomized bench for ps2_lane_keys against a behavioural key/event model; a second instance runs with parity ignored.
module tb_ps2_lane_keys;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       key_clk = 1'b1;
    logic       key_data = 1'b1;
    logic       evt_ready = 1'b0;

    logic [4:0] key_down, key_press, np_key_down, np_key_press;
    logic       evt_valid, evt_break, evt_ext, parity_err, frame_err, overflow;
    logic [7:0] evt_code, np_evt_code;
    logic       np_evt_valid, np_evt_break, np_evt_ext, np_parity_err, np_frame_err, np_overflow;

    always #5 clk_in = ~clk_in;

    ps2_lane_keys u_dut (
        .clk_in(clk_in), .rst(rst), .key_clk(key_clk), .key_data(key_data),
        .key_down(key_down), .key_press(key_press), .evt_valid(evt_valid),
        .evt_ready(evt_ready), .evt_code(evt_code), .evt_break(evt_break),
        .evt_ext(evt_ext), .parity_err(parity_err), .frame_err(frame_err),
        .overflow(overflow)
    );

    ps2_lane_keys #(.PARITY_CHECK(0)) u_dut_np (
        .clk_in(clk_in), .rst(rst), .key_clk(key_clk), .key_data(key_data),
        .key_down(np_key_down), .key_press(np_key_press), .evt_valid(np_evt_valid),
        .evt_ready(1'b1), .evt_code(np_evt_code), .evt_break(np_evt_break),
        .evt_ext(np_evt_ext), .parity_err(np_parity_err), .frame_err(np_frame_err),
        .overflow(np_overflow)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: index 0 = parity enforced, 1 = parity ignored.
    logic [7:0] lane [5] = '{8'h1C, 8'h1B, 8'h42, 8'h4B, 8'h5A};
    logic [4:0] m_down [2];
    bit         m_brk [2];
    bit         m_ext [2];
    int         m_press [2][5];
    logic [9:0] m_q [$];
    bit         m_ovf;
    int         m_par, m_fr;

    int d_press [2][5];
    int d_par [2];
    int d_fr [2];

    initial begin
        for (int m = 0; m < 2; m++) begin
            m_down[m] = '0; m_brk[m] = 0; m_ext[m] = 0;
            d_par[m] = 0; d_fr[m] = 0;
            for (int k = 0; k < 5; k++) begin m_press[m][k] = 0; d_press[m][k] = 0; end
        end
        m_ovf = 0; m_par = 0; m_fr = 0;
    end

    always @(negedge clk_in) begin
        if (!rst) begin
            for (int k = 0; k < 5; k++) begin
                if (key_press[k] === 1'b1)    d_press[0][k]++;
                if (np_key_press[k] === 1'b1) d_press[1][k]++;
            end
            if (parity_err === 1'b1)    d_par[0]++;
            if (np_parity_err === 1'b1) d_par[1]++;
            if (frame_err === 1'b1)     d_fr[0]++;
            if (np_frame_err === 1'b1)  d_fr[1]++;
        end
    end

    task automatic model_byte(input int m, input logic [7:0] b);
        if (b == 8'hF0) begin
            m_brk[m] = 1;
        end else if (b == 8'hE0) begin
            m_ext[m] = 1;
        end else begin
            if (m == 0) begin
                if (m_q.size() < 8) m_q.push_back({b, m_brk[m], m_ext[m]});
                else                m_ovf = 1;
            end
            if (!m_ext[m]) begin
                for (int k = 0; k < 5; k++) begin
                    if (b == lane[k]) begin
                        if (m_brk[m]) begin
                            m_down[m][k] = 1'b0;
                        end else begin
                            if (!m_down[m][k]) m_press[m][k]++;
                            m_down[m][k] = 1'b1;
                        end
                    end
                end
            end
            m_brk[m] = 0;
            m_ext[m] = 0;
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_down[m] = '0; m_brk[m] = 0; m_ext[m] = 0;
        end
        m_q.delete();
        m_ovf = 0;
    endtask

    task automatic ps2_bit(input bit v);
        key_data = v;
        #100;
        key_clk = 1'b0;
        #100;
        key_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(~bad_stop);
        key_data = 1'b1;
        #300;
        if (bad_par)  m_par++;
        if (bad_stop) m_fr++;
        if (!bad_stop && !bad_par) model_byte(0, b);
        if (!bad_stop)             model_byte(1, b);
    endtask

    task automatic check_state(input string where);
        @(negedge clk_in);
        check({where, ".key_down"},    32'(key_down),    32'(m_down[0]));
        check({where, ".np_key_down"}, 32'(np_key_down), 32'(m_down[1]));
        for (int k = 0; k < 5; k++) begin
            check($sformatf("%s.press%0d", where, k),    32'(d_press[0][k]), 32'(m_press[0][k]));
            check($sformatf("%s.np_press%0d", where, k), 32'(d_press[1][k]), 32'(m_press[1][k]));
        end
        check({where, ".parity_err_cnt"},    32'(d_par[0]), 32'(m_par));
        check({where, ".np_parity_err_cnt"}, 32'(d_par[1]), 32'd0);
        check({where, ".frame_err_cnt"},     32'(d_fr[0]),  32'(m_fr));
        check({where, ".np_frame_err_cnt"},  32'(d_fr[1]),  32'(m_fr));
        check({where, ".overflow"},          32'(overflow), 32'(m_ovf));
    endtask

    task automatic drain(input string where);
        logic [9:0] exp;
        int guard;
        while (m_q.size() > 0) begin
            exp = m_q.pop_front();
            guard = 0;
            @(negedge clk_in);
            while (evt_valid !== 1'b1 && guard < 50) begin
                @(negedge clk_in);
                guard++;
            end
            check({where, ".evt_valid"}, 32'(evt_valid), 32'd1);
            check({where, ".evt_code"},  32'(evt_code),  32'(exp[9:2]));
            check({where, ".evt_break"}, 32'(evt_break), 32'(exp[1]));
            check({where, ".evt_ext"},   32'(evt_ext),   32'(exp[0]));
            evt_ready = 1'b1;
            @(negedge clk_in);
            evt_ready = 1'b0;
        end
        @(negedge clk_in);
        check({where, ".fifo_empty"}, 32'(evt_valid), 32'd0);
    endtask

    task automatic check_zero(input string where);
        check({where, ".key_down"},   32'(key_down),   32'd0);
        check({where, ".key_press"},  32'(key_press),  32'd0);
        check({where, ".evt_valid"},  32'(evt_valid),  32'd0);
        check({where, ".evt_code"},   32'(evt_code),   32'd0);
        check({where, ".evt_break"},  32'(evt_break),  32'd0);
        check({where, ".evt_ext"},    32'(evt_ext),    32'd0);
        check({where, ".parity_err"}, 32'(parity_err), 32'd0);
        check({where, ".frame_err"},  32'(frame_err),  32'd0);
        check({where, ".overflow"},   32'(overflow),   32'd0);
    endtask

    initial begin : stim
        logic [7:0] b;
        int r;
        #53;
        check_zero("reset");
        rst = 1'b0;
        #300;

        send_frame(8'h1C, 0, 0);
        check_state("make_a");
        check("make_a.down_const", 32'(key_down), 32'h01);
        drain("make_a");

        send_frame(8'hF0, 0, 0);
        send_frame(8'h1C, 0, 0);
        check_state("release_a");
        check("release_a.down_const", 32'(key_down), 32'h00);
        drain("release_a");

        repeat (3) send_frame(8'h1B, 0, 0);
        check_state("repeat_s");
        check("repeat_s.down_const", 32'(key_down), 32'h02);
        drain("repeat_s");

        send_frame(8'h1C, 1, 0);
        check_state("bad_parity");
        check("bad_parity.down_const",    32'(key_down),    32'h02);
        check("bad_parity.np_down_const", 32'(np_key_down), 32'h03);
        drain("bad_parity");

        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(i[0]);
        key_data = 1'b1;
        #101000;
        m_fr++;
        check_state("timeout");
        send_frame(8'h4B, 0, 0);
        check_state("after_timeout");
        check("after_timeout.down3", 32'(key_down[3]), 32'd1);
        drain("after_timeout");

        send_frame(8'hE0, 0, 0);
        send_frame(8'h1C, 0, 0);
        check_state("extended");
        drain("extended");

        for (int i = 0; i < 9; i++) send_frame(8'h10 + 8'(i), 0, 0);
        check_state("overflow");
        check("overflow.const", 32'(overflow), 32'd1);
        drain("overflow");

        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            if (r < 5)       b = lane[r];
            else if (r == 5) b = 8'hF0;
            else if (r == 6) b = 8'hE0;
            else             b = 8'($urandom_range(0, 255));
            send_frame(b, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
            #($urandom_range(0, 200));
            if (n % 6 == 5) begin
                check_state($sformatf("rand%0d", n));
                drain($sformatf("rand%0d", n));
            end
        end
        check_state("rand_end");
        drain("rand_end");

        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1);
        key_data = 1'b0;
        #50;
        rst = 1'b1;
        key_clk = 1'b1;
        key_data = 1'b1;
        #50;
        check_zero("mid_reset");
        model_reset();
        rst = 1'b0;
        #300;
        send_frame(8'h5A, 0, 0);
        check_state("post_reset");
        check("post_reset.down4", 32'(key_down), 32'h10);
        drain("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
